// File: rtl/pwmwdg_ctrl.sv
// pwmwdg_ctrl: Wishbone-controlled PWM bank with shared prescaler and a watchdog.
// The watchdog is built only when PWMWDG_WATCHDOG_EN is defined.
module pwmwdg_ctrl #(
    parameter int PWM_CH = 4,
    parameter int PWM_W  = 8,
    parameter int WDG_W  = 26
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              PWC_STB_I,
    input  logic              PWC_WE_I,
    input  logic [5:0]        PWC_ADR_I,
    input  logic [31:0]       PWC_DAT_I,
    output logic              PWC_ACK_O,
    output logic [31:0]       PWC_DAT_O,
    output logic              PWC_ERR_O,
    output logic              PWC_RTY_O,
    output logic [PWM_CH-1:0] PWM_O,
    output logic              WATCH_DOG
);
    logic              ack_q, acc, wr, tick, wrap, unused;
    logic [3:0]        idx;
    logic [31:0]       dat_q, rdata;
    logic [PWM_CH-1:0] en_q, en_d;
    logic [15:0]       presc_q, presc_d, pre_q, pre_d;
    logic [PWM_W-1:0]  pwm_q, pwm_d;
    logic [PWM_W-1:0]  duty_q [PWM_CH];
    logic [PWM_W-1:0]  duty_d [PWM_CH];
    logic [PWM_W-1:0]  shd_q [PWM_CH];
    logic [PWM_W-1:0]  shd_d [PWM_CH];

    assign acc       = PWC_STB_I & ~ack_q;
    assign wr        = acc & PWC_WE_I;
    assign idx       = PWC_ADR_I[5:2];
    assign PWC_ACK_O = ack_q;
    assign PWC_DAT_O = dat_q;
    assign PWC_ERR_O = 1'b0;
    assign PWC_RTY_O = 1'b0;
    assign unused    = ^{PWC_DAT_I, PWC_ADR_I[1:0]};

    assign tick    = pre_q == presc_q;
    assign wrap    = tick & (&pwm_q);
    assign en_d    = wr && idx == 4'd0 ? PWC_DAT_I[PWM_CH-1:0] : en_q;
    assign presc_d = wr && idx == 4'd1 ? PWC_DAT_I[15:0] : presc_q;
    assign pre_d   = (wr && idx == 4'd1) || tick ? '0 : pre_q + 16'd1;
    assign pwm_d   = tick ? pwm_q + PWM_W'(1) : pwm_q;

    // Shadows only move at a period boundary, so a new duty never cuts a period short.
    always_comb begin
        for (int n = 0; n < PWM_CH; n++) begin
            duty_d[n] = wr && idx == 4'(n + 4) ? PWC_DAT_I[PWM_W-1:0] : duty_q[n];
            shd_d[n]  = !en_q[n] || wrap ? duty_q[n] : shd_q[n];
            PWM_O[n]  = en_q[n] && pwm_q >= shd_q[n];
        end
    end

`ifdef PWMWDG_WATCHDOG_EN
    logic             wen_q, wen_d, flag_q, flag_d, wdg_wr;
    logic [WDG_W-1:0] wcnt_q, wcnt_d;

    assign wdg_wr    = wr && idx == 4'd2;
    assign wen_d     = wdg_wr ? PWC_DAT_I[0] : wen_q;
    assign wcnt_d    = wdg_wr && (wen_q || PWC_DAT_I[0]) ? PWC_DAT_I[WDG_W:1] :
                       wcnt_q != '0 ? wcnt_q - WDG_W'(1) : wcnt_q;
    assign flag_d    = (wen_q && wcnt_q == WDG_W'(1)) ||
                       (flag_q && !(wr && idx == 4'd3 && PWC_DAT_I[0]));
    assign WATCH_DOG = wen_q && (wcnt_q == WDG_W'(1) || wcnt_q == WDG_W'(2));

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wen_q  <= 1'b0;
            wcnt_q <= '0;
            flag_q <= 1'b0;
        end else begin
            wen_q  <= wen_d;
            wcnt_q <= wcnt_d;
            flag_q <= flag_d;
        end
    end
`else
    localparam int unused_wdg_w = WDG_W;
    assign WATCH_DOG = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (idx)
            4'd0: rdata = 32'(en_q);
            4'd1: rdata = 32'(presc_q);
`ifdef PWMWDG_WATCHDOG_EN
            4'd2: rdata = 32'({wcnt_q, wen_q});
            4'd3: rdata = 32'(flag_q);
`endif
            default: begin
                for (int n = 0; n < PWM_CH; n++)
                    if (idx == 4'(n + 4)) rdata = 32'(duty_q[n]);
            end
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            en_q    <= '0;
            presc_q <= '0;
            pre_q   <= '0;
            pwm_q   <= '0;
            for (int n = 0; n < PWM_CH; n++) begin
                duty_q[n] <= '0;
                shd_q[n]  <= '0;
            end
        end else begin
            ack_q   <= acc;
            if (acc) dat_q <= rdata;
            en_q    <= en_d;
            presc_q <= presc_d;
            pre_q   <= pre_d;
            pwm_q   <= pwm_d;
            duty_q  <= duty_d;
            shd_q   <= shd_d;
        end
    end
endmodule

// File: tb/tb_pwmwdg_ctrl.sv
// tb_pwmwdg_ctrl: randomized scoreboard bench for pwmwdg_ctrl with a behavioural model.
`timescale 1ns/1ps
module tb_pwmwdg_ctrl;
    localparam int CH = 4, W = 8, WW = 26, PER = 1 << W;

    logic          clk = 0, rst = 1, stb = 0, we = 0;
    logic [5:0]    adr = '0;
    logic [31:0]   wdat = '0;
    logic          ack, err, rty, wd;
    logic [31:0]   rdat;
    logic [CH-1:0] pwm;

    int checks = 0, errors = 0;
    logic [38:0] sb_q[$];
    logic [38:0] sb_e;

    logic [CH-1:0] m_en;
    logic [15:0]   m_presc;
    logic [W-1:0]  m_duty [CH];

    int lo, hi, n, p, r;
    logic prev;
    logic [5:0] ra;
    logic [31:0] rv;
    logic [CH-1:0] mask;
    logic [W-1:0] d [CH];
    int hc [CH];
    logic [63:0] pat, epat;
    logic [4:0] ap;

    always #5 clk = ~clk;

    pwmwdg_ctrl #(.PWM_CH(CH), .PWM_W(W), .WDG_W(WW)) dut (
        .CLK_I(clk), .RST_I(rst), .PWC_STB_I(stb), .PWC_WE_I(we), .PWC_ADR_I(adr),
        .PWC_DAT_I(wdat), .PWC_ACK_O(ack), .PWC_DAT_O(rdat), .PWC_ERR_O(err),
        .PWC_RTY_O(rty), .PWM_O(pwm), .WATCH_DOG(wd)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic void mwrite(input logic [5:0] a, input logic [31:0] v);
        int i = int'(a[5:2]);
        if (i == 0) m_en = v[CH-1:0];
        else if (i == 1) m_presc = v[15:0];
        else if (i >= 4 && i < 4 + CH) m_duty[i-4] = v[W-1:0];
    endfunction

    function automatic logic [31:0] mread(input logic [5:0] a);
        int i = int'(a[5:2]);
        if (i == 0) return 32'(m_en);
        if (i == 1) return 32'(m_presc);
        if (i >= 4 && i < 4 + CH) return 32'(m_duty[i-4]);
        return '0;
    endfunction

    // One Wishbone access; the expected response goes to the scoreboard.
    task automatic bus(input logic w, input logic [5:0] a, input logic [31:0] v, input logic [31:0] exp);
        @(posedge clk); #1;
        stb = 1; we = w; adr = a; wdat = v;
        sb_q.push_back({~w, a, exp});
        @(posedge clk); #1;
        stb = 0; we = 0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] v);
        mwrite(a, v);
        bus(1'b1, a, v, '0);
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] exp);
        bus(1'b0, a, '0, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && ack) begin
            if (sb_q.size() == 0) chk("unexpected_ack", 1, 0);
            else begin
                sb_e = sb_q.pop_front();
                if (sb_e[38]) begin
                    checks++;
                    if (rdat !== sb_e[31:0]) begin
                        errors++;
                        $display("FAIL read@0x%0h: got 0x%0h expected 0x%0h", {sb_e[37:32], 2'b00} >> 2 << 2, rdat, sb_e[31:0]);
                    end
                end
            end
        end
    end

    task automatic runs(input int ch, output int l, output int h);
        int k = 0;
        logic pv;
        do begin pv = pwm[ch]; @(negedge clk); k++; end while (!(pv && !pwm[ch]) && k < 5000);
        l = 0;
        while (!pwm[ch] && l < 5000) begin l++; @(negedge clk); end
        h = 0;
        while (pwm[ch] && h < 5000) begin h++; @(negedge clk); end
    endtask

    task automatic wdg_pulse(input int rl);
        wr(6'h08, 32'((rl << 1) | 1));
        pat = '0; epat = '0;
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            pat[j] = wd;
            epat[j] = (rl - j == 1) || (rl - j == 2);
        end
        chk($sformatf("wdg_pulse_r%0d", rl), pat, epat);
    endtask

    initial begin
        #3ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        m_en = '0; m_presc = '0;
        for (int c = 0; c < CH; c++) m_duty[c] = '0;
        #2;
        chk("rst_pwm", pwm, 0);
        chk("rst_wdg", wd, 0);
        chk("rst_ack", ack, 0);
        chk("rst_dat", rdat, 0);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("err_rty", {err, rty}, 0);
        for (int a = 0; a < 16; a++) rd(6'(a * 4), '0);

        // Held strobe: acks alternate with idle cycles.
        wr(6'h04, 32'h55);
        @(posedge clk); #1;
        stb = 1; we = 0; adr = 6'h04;
        sb_q.push_back({1'b1, 6'h04, 32'h55});
        sb_q.push_back({1'b1, 6'h04, 32'h55});
        for (int j = 0; j < 5; j++) begin @(negedge clk); ap[j] = ack; end
        stb = 0;
        chk("ack_alternate", ap, 5'b01010);

        for (int i = 0; i < 12; i++) begin
            n = $urandom_range(0, 15);
            if (n == 2 || n == 3) n += 4;
            ra = {4'(n), 2'($urandom)};
            rv = $urandom;
            wr(ra, rv);
            rd(ra, mread(ra));
        end
        wr(6'h20, 32'hFF);
        rd(6'h20, '0);

        wr(6'h00, 0); wr(6'h10, 32'h40); wr(6'h04, 0); wr(6'h00, 1);
        runs(0, lo, hi);
        chk("p0_low", lo, 64);
        chk("p0_high", hi, 192);

        n = 0;
        do begin prev = pwm[0]; @(negedge clk); n++; end while (!(!prev && pwm[0]) && n < 5000);
        fork
            begin hi = 0; while (pwm[0] && hi < 5000) begin hi++; @(negedge clk); end end
            begin repeat (20) @(posedge clk); wr(6'h10, 32'h80); end
        join
        chk("mid_high_kept", hi, 192);
        lo = 0; while (!pwm[0] && lo < 5000) begin lo++; @(negedge clk); end
        hi = 0; while (pwm[0] && hi < 5000) begin hi++; @(negedge clk); end
        chk("new_duty_low", lo, 128);
        chk("new_duty_high", hi, 128);

        wr(6'h00, 0); wr(6'h10, 32'h40); wr(6'h04, 3); wr(6'h00, 1);
        runs(0, lo, hi);
        chk("presc3_low", lo, 256);
        chk("presc3_high", hi, 768);

        for (int it = 0; it < 3; it++) begin
            p = $urandom_range(0, 3);
            wr(6'h00, 0);
            for (int c = 0; c < CH; c++) begin
                d[c] = W'($urandom);
                if (it == 0) d[c] = c == 0 ? '0 : c == 1 ? '1 : d[c];
                wr(6'(16 + 4 * c), 32'(d[c]));
            end
            mask = it == 0 ? '1 : CH'($urandom);
            wr(6'h04, p);
            wr(6'h00, 32'(mask));
            repeat (5) @(negedge clk);
            for (int c = 0; c < CH; c++) hc[c] = 0;
            repeat (PER * (p + 1)) begin
                @(negedge clk);
                for (int c = 0; c < CH; c++) hc[c] += int'(pwm[c]);
            end
            for (int c = 0; c < CH; c++)
                chk($sformatf("duty_it%0d_ch%0d", it, c), hc[c], mask[c] ? (PER - int'(d[c])) * (p + 1) : 0);
        end

`ifdef PWMWDG_WATCHDOG_EN
        wdg_pulse(10);
        rd(6'h0C, 1);
        rd(6'h08, 1);
        wr(6'h0C, 1);
        rd(6'h0C, 0);
        wdg_pulse(1);
        wdg_pulse(2);
        wdg_pulse($urandom_range(3, 60));
        wdg_pulse($urandom_range(3, 60));
        wr(6'h0C, 1);
        rd(6'h0C, 0);
        // Clear lands on the same cycle as the set: the set must win.
        wr(6'h08, (2 << 1) | 1);
        wr(6'h0C, 1);
        rd(6'h0C, 1);
        wr(6'h0C, 1);
        rd(6'h0C, 0);

        wr(6'h08, (50 << 1) | 1);
        wr(6'h08, 30 << 1);
        rd(6'h08, 29 << 1);
        pat = '0;
        for (int j = 0; j < 40; j++) begin @(negedge clk); pat[j] = wd; end
        chk("wdg_disabled_no_pulse", pat, 0);
        rd(6'h08, 0);
        wr(6'h08, 30 << 1);
        rd(6'h08, 0);
        rd(6'h0C, 0);
`else
        wr(6'h08, (10 << 1) | 1);
        rd(6'h08, 0);
        wr(6'h0C, 1);
        rd(6'h0C, 0);
        pat = '0;
        for (int j = 0; j < 20; j++) begin @(negedge clk); pat[j] = wd; end
        chk("wdg_absent", pat, 0);
`endif

        wr(6'h00, 0); wr(6'h10, 0); wr(6'h00, 1);
`ifdef PWMWDG_WATCHDOG_EN
        wr(6'h08, (20 << 1) | 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!wd && n < 100);
        chk("pre_rst_wdg", wd, 1);
`else
        @(negedge clk);
`endif
        chk("pre_rst_pwm", pwm[0], 1);
        #2 rst = 1;
        #1;
        chk("async_rst_pwm", pwm, 0);
        chk("async_rst_wdg", wd, 0);
        chk("async_rst_dat", rdat, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        m_en = '0; m_presc = '0;
        for (int c = 0; c < CH; c++) m_duty[c] = '0;
        for (int a = 0; a < 16; a++) rd(6'(a * 4), mread(6'(a * 4)));
        chk("post_rst_pwm", pwm, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
